// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared pipeline definitions: wait FSM encoding, hazard priority classes,
// and the helper that ranks simultaneous hazards.
package id_ex_hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Ordered so a larger value always wins when several hazards coincide.
  typedef enum logic [1:0] {
    PRI_NONE     = 2'd0,
    PRI_LOAD_USE = 2'd1,
    PRI_BR_FLUSH = 2'd2,
    PRI_MEM_WAIT = 2'd3
  } hazard_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A memory freeze beats a taken branch, which beats a load-use stall.
  // A taken branch discards the ID instruction, so its load-use is moot.
  function automatic hazard_e resolveHazard(input logic memWait,
                                            input logic brFlush,
                                            input logic loadUse);
    hazard_e hz;
    hz = PRI_NONE;
    if (memWait) begin
      hz = PRI_MEM_WAIT;
    end else if (brFlush) begin
      hz = PRI_BR_FLUSH;
    end else if (loadUse) begin
      hz = PRI_LOAD_USE;
    end
    return hz;
  endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count one event per cycle until the counter is full, then hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, taken-branch and memory-wait
// hazards into stall/flush controls, watches for stuck memory accesses and
// keeps saturating stall/flush statistics.
module id_ex_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dst,
  input  logic             ex_Mem2Reg,
  input  logic             ex_regWr,
  input  logic [1:0]       ex_branch,
  input  logic             ex_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import id_ex_hazard_ctrl_pkg::*;

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);

  logic              w_loadUse;
  logic              w_brFlush;
  logic              w_memWait;
  hazard_e           w_hazard;

  state_e            r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_memTimeout;

  assign w_loadUse = ex_Mem2Reg && ex_regWr && (ex_dst != REG_ZERO) &&
                     ((id_uses_rs && (id_rs == ex_dst)) ||
                      (id_uses_rt && (id_rt == ex_dst)));
  assign w_brFlush = (ex_branch != 2'b00) && ex_taken;
  assign w_memWait = mem_access && !dmem_ready;
  assign w_hazard  = resolveHazard(w_memWait, w_brFlush, w_loadUse);

  // Translate the winning hazard into same-cycle stall/flush controls.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (w_hazard)
      PRI_MEM_WAIT: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end
      PRI_BR_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      PRI_LOAD_USE: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Track memory-wait episodes and latch a sticky timeout when one runs too long.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_waitCnt <= '0;
          if (w_memWait) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_waitCnt != TIMEOUT_V) begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
          if (w_memWait && (r_waitCnt == TIMEOUT_M1)) begin
            r_memTimeout <= 1'b1;
          end
          if (!w_memWait) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign mem_timeout = r_memTimeout;

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (pc_stall),
    .o_count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (ifid_flush),
    .o_count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed hazard scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_id_ex_hazard_ctrl;

  localparam int TO      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_dst;
  logic          id_uses_rs, id_uses_rt, ex_Mem2Reg, ex_regWr;
  logic [1:0]    ex_branch;
  logic          ex_taken, mem_access, dmem_ready;
  logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic          ifid_flush, idex_bubble, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  int mStall;
  int mFlush;
  int mRun;
  bit mTimeout;
  bit checkEn = 1'b0;

  id_ex_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_dst      (ex_dst),
    .ex_Mem2Reg  (ex_Mem2Reg),
    .ex_regWr    (ex_regWr),
    .ex_branch   (ex_branch),
    .ex_taken    (ex_taken),
    .mem_access  (mem_access),
    .dmem_ready  (dmem_ready),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .idex_stall  (idex_stall),
    .exmem_stall (exmem_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {pc,ifid_stall,idex_stall,exmem_stall,ifid_flush,idex_bubble} from the hazard rules.
  function automatic logic [5:0] expectComb();
    bit lu, bf, mw;
    lu = ex_Mem2Reg && ex_regWr && (ex_dst != 0) &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    bf = (ex_branch != 0) && ex_taken;
    mw = mem_access && !dmem_ready;
    if (mw)      return 6'b111100;
    else if (bf) return 6'b000011;
    else if (lu) return 6'b110001;
    else         return 6'b000000;
  endfunction

  function automatic logic [5:0] actComb();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_bubble};
  endfunction

  task automatic resetModel();
    mStall   = 0;
    mFlush   = 0;
    mRun     = 0;
    mTimeout = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelUpdate();
    logic [5:0] e;
    if (rst) begin
      e = expectComb();
      if (e[5] && mStall < CNT_MAX) mStall++;
      if (e[1] && mFlush < CNT_MAX) mFlush++;
      if (mem_access && !dmem_ready) mRun++;
      else                           mRun = 0;
      if (mRun >= TO + 1) mTimeout = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                               input bit urs, input bit urt, input bit m2r, input bit rw,
                               input logic [1:0] br, input bit tk, input bit ma, input bit dr);
    id_rs = rs; id_rt = rt; ex_dst = dst;
    id_uses_rs = urs; id_uses_rt = urt;
    ex_Mem2Reg = m2r; ex_regWr = rw;
    ex_branch = br; ex_taken = tk;
    mem_access = ma; dmem_ready = dr;
  endtask

  task automatic clearInputs();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  // Pulse reset between edges and release it one cycle later.
  task automatic doReset();
    rst = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Continuous comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_comb", actComb(), expectComb());
      checkOutput("model_stall_cnt", stall_cnt, mStall);
      checkOutput("model_flush_cnt", flush_cnt, mFlush);
      checkOutput("model_timeout", mem_timeout, mTimeout);
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int burstLeft;
    rst = 1'b0;
    clearInputs();
    resetModel();
    checkEn = 1'b1;
    #1;
    checkOutput("reset_comb", actComb(), 6'b000000);
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    checkOutput("reset_flush_cnt", flush_cnt, 0);
    checkOutput("reset_timeout", mem_timeout, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load-use on rs: one bubble, one counted stall.
    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("lu_outputs", actComb(), 6'b110001);
    tick();
    clearInputs();
    #2;
    checkOutput("lu_released", pc_stall, 0);
    checkOutput("lu_stall_cnt", stall_cnt, 1);

    // Same pattern against register zero never stalls.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("r0_outputs", actComb(), 6'b000000);
    tick();

    // Taken branch swallows a simultaneous load-use.
    applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    #2;
    checkOutput("br_lu_outputs", actComb(), 6'b000011);
    tick();
    clearInputs();
    #2;
    checkOutput("br_flush_cnt", flush_cnt, 1);
    checkOutput("br_stall_cnt", stall_cnt, 1);

    // Memory freeze holds off a pending taken branch for three cycles.
    doReset();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("freeze_outputs", actComb(), 6'b111100);
      tick();
    end
    checkOutput("freeze_stall_cnt", stall_cnt, 3);
    checkOutput("freeze_flush_cnt", flush_cnt, 0);
    dmem_ready = 1'b1;
    #2;
    checkOutput("freeze_then_flush", actComb(), 6'b000011);
    tick();
    clearInputs();
    #2;
    checkOutput("freeze_flush_cnt_after", flush_cnt, 1);

    // Six waiting cycles: timeout appears after the fifth edge and is sticky.
    doReset();
    mem_access = 1'b1;
    dmem_ready = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      #2;
      checkOutput("timeout_edge", mem_timeout, (e >= 5) ? 1 : 0);
    end
    dmem_ready = 1'b1;
    tick();
    tick();
    #2;
    checkOutput("timeout_sticky", mem_timeout, 1);

    // Reset in the middle of a wait clears state without any clock edge.
    dmem_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput("midwait_timeout", mem_timeout, 0);
    checkOutput("midwait_stall_cnt", stall_cnt, 0);
    checkOutput("midwait_flush_cnt", flush_cnt, 0);
    checkOutput("midwait_comb", actComb(), 6'b111100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      #2;
      checkOutput("midwait_restart", mem_timeout, (e >= 5) ? 1 : 0);
    end
    clearInputs();
    tick();

    // Randomized traffic with occasional long memory bursts and resets.
    burstLeft = 0;
    for (int i = 0; i < 1500; i++) begin
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      ex_dst     = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_Mem2Reg = 1'($urandom_range(0, 1));
      ex_regWr   = ($urandom_range(0, 3) != 0);
      ex_branch  = 2'($urandom_range(0, 3));
      ex_taken   = 1'($urandom_range(0, 1));
      if (burstLeft > 0) begin
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        burstLeft--;
      end else begin
        mem_access = 1'($urandom_range(0, 1));
        dmem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) burstLeft = $urandom_range(3, 9);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        resetModel();
      end else begin
        rst = 1'b1;
      end
      tick();
    end

    rst = 1'b1;
    clearInputs();
    tick();
    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
